// File: rtl/load_store_unit.sv
// Load/store initiator for the data memory port; one request in flight, response pulse per request.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned halfword/word accesses into byte accesses.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
`ifdef LSU_MISALIGN_SPLIT_EN
    , SPLIT
`endif
  } state_t;

  state_t      state;
  logic        is_store_q;
  logic        fault_q;
  logic [31:0] result_q;
  logic        illegal;
  logic        misaligned;
  logic [31:0] load_value;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [1:0]        idx_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx_next;
  logic [1:0]        idx_last;

  assign idx_next = idx_q + 2'd1;
  assign idx_last = funct3_q[1] ? 2'd3 : 2'd1;
`endif

  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_is_store && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Aligned loads are already extended by the memory; only split halfwords need it here.
  always_comb begin
    load_value = result_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (split_q && (funct3_q[1:0] == 2'b01))
      load_value = funct3_q[2] ? {16'h0000, result_q[15:0]}
                               : {{16{result_q[15]}}, result_q[15:0]};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_fault      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_funct3     <= '0;
      is_store_q     <= 1'b0;
      fault_q        <= 1'b0;
      result_q       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q        <= 1'b0;
      idx_q          <= '0;
      funct3_q       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready      <= 1'b0;
            is_store_q     <= req_is_store;
            result_q       <= '0;
            mem_address    <= req_addr;
            mem_funct3     <= req_funct3;
            mem_write_data <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            funct3_q       <= req_funct3;
            addr_q         <= req_addr;
            wdata_q        <= req_wdata;
            split_q        <= 1'b0;
            idx_q          <= '0;
`endif
            if (illegal) begin
              fault_q <= 1'b1;
              state   <= RESP;
            end else if (misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
              fault_q        <= 1'b0;
              split_q        <= 1'b1;
              mem_funct3     <= req_is_store ? 3'b000 : 3'b100;
              mem_write_data <= {24'h000000, req_wdata[7:0]};
              mem_read       <= !req_is_store;
              mem_write      <= req_is_store;
              state          <= SPLIT;
`else
              fault_q <= 1'b1;
              state   <= RESP;
`endif
            end else begin
              fault_q   <= 1'b0;
              mem_read  <= !req_is_store;
              mem_write <= req_is_store;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (!is_store_q) result_q <= mem_read_data;
          state <= RESP;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          if (!is_store_q) result_q[{idx_q, 3'b000} +: 8] <= mem_read_data[7:0];
          if (idx_q == idx_last) begin
            // Memory-side fields go back to the latched request once bytes are done.
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= addr_q;
            mem_funct3     <= funct3_q;
            mem_write_data <= wdata_q;
            state          <= RESP;
          end else begin
            idx_q          <= idx_next;
            mem_address    <= addr_q + ADDR_W'(idx_next);
            mem_write_data <= {24'h000000, wdata_q[{idx_next, 3'b000} +: 8]};
          end
        end
`endif
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_fault <= fault_q;
          rsp_rdata <= (is_store_q || fault_q) ? '0 : load_value;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
